// File: rtl/his_pkg.sv
// Shared defaults, FSM state encoding and bin-index helper for the
// per-pixel histogram builder.
package his_pkg;

  localparam int DEF_DATA_W            = 10;
  localparam int DEF_PIXEL_NUM         = 3;
  localparam int DEF_SAMPLES_PER_PIXEL = 2;
  localparam int DEF_ACQ_NUM           = 2;
  localparam int DEF_BIN_BITS          = 4;
  localparam int DEF_NBINS             = 2 ** DEF_BIN_BITS;
  localparam int DEF_CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_ACC    = 2'd0,
    ST_SEARCH = 2'd1,
    ST_UPDATE = 2'd2
  } his_state_e;

  // The bin is the top bin_bits of the code.
  function automatic int unsigned bin_index(input int unsigned code,
                                            input int data_w,
                                            input int bin_bits);
    return (code >> (data_w - bin_bits)) & ((32'd1 << bin_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/his_builder_fsm_peak_scan.sv
// his_peak_scan: sequential argmax over a stream of (index, value) pairs.
// 'start' marks the first element and loads it unconditionally; afterwards
// only a strictly greater value replaces the held peak, so ties keep the
// earliest (lowest) index and an all-zero stream yields the first index.
module his_peak_scan #(
  parameter int CNT_W = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] val,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] peak
);

  logic [CNT_W-1:0] max_val;

  // Running maximum and its index.
  always_ff @(posedge clk) begin
    if (res) begin
      max_val <= '0;
      peak    <= '0;
    end else if (en && (start || val > max_val)) begin
      max_val <= val;
      peak    <= idx;
    end
  end

endmodule

// File: rtl/his_builder_fsm.sv
// his_builder_fsm: bins pixel-major TOF codes into per-pixel histograms over
// ACQ_NUM acquisitions, scans each histogram for its peak bin (one bin per
// cycle), publishes the bin lower edges and clears the histograms.
// Optional macro HIS_BIN_SAT_EN: bin counters saturate instead of wrapping.
module his_builder_fsm
  import his_pkg::*;
#(
  parameter int DATA_W            = DEF_DATA_W,
  parameter int PIXEL_NUM         = DEF_PIXEL_NUM,
  parameter int SAMPLES_PER_PIXEL = DEF_SAMPLES_PER_PIXEL,
  parameter int ACQ_NUM           = DEF_ACQ_NUM,
  parameter int BIN_BITS          = DEF_BIN_BITS,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] peakResult [PIXEL_NUM-1:0]
);

  localparam int NBINS = 2 ** BIN_BITS;
  localparam int SW = (SAMPLES_PER_PIXEL > 1) ? $clog2(SAMPLES_PER_PIXEL) : 1;
  localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  localparam logic [1:0] ACC    = ST_ACC;
  localparam logic [1:0] SEARCH = ST_SEARCH;
  localparam logic [1:0] UPDATE = ST_UPDATE;

  logic [1:0]          state;
  logic [SW-1:0]       sample_cnt;
  logic [PW-1:0]       pix;
  logic [AW-1:0]       acq_cnt;
  logic [PW-1:0]       scan_pix;
  logic [BIN_BITS-1:0] scan_bin;
  logic [BIN_BITS-1:0] bin;
  logic [CNT_W-1:0]    hist     [PIXEL_NUM][NBINS];
  logic [BIN_BITS-1:0] peak_bin [PIXEL_NUM];

  logic accept, last_sample, last_pix, last_acq, last_bin, scan_last;

  assign bin         = BIN_BITS'(bin_index(32'(data), DATA_W, BIN_BITS));
  assign accept      = (state == ACC) && wrEn;
  assign last_sample = sample_cnt == SW'(SAMPLES_PER_PIXEL - 1);
  assign last_pix    = pix == PW'(PIXEL_NUM - 1);
  assign last_acq    = acq_cnt == AW'(ACQ_NUM - 1);
  assign last_bin    = &scan_bin;
  assign scan_last   = last_bin && (scan_pix == PW'(PIXEL_NUM - 1));

  function automatic logic [CNT_W-1:0] bin_inc(input logic [CNT_W-1:0] c);
`ifdef HIS_BIN_SAT_EN
    return (&c) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  // Sequencing: input counters in ACC, bin walk in SEARCH, one-cycle UPDATE.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= ACC;
      sample_cnt <= '0;
      pix        <= '0;
      acq_cnt    <= '0;
      scan_pix   <= '0;
      scan_bin   <= '0;
    end else begin
      case (state)
        ACC: if (wrEn) begin
          sample_cnt <= last_sample ? '0 : sample_cnt + 1'b1;
          if (last_sample) pix <= last_pix ? '0 : pix + 1'b1;
          if (last_sample && last_pix) acq_cnt <= last_acq ? '0 : acq_cnt + 1'b1;
          if (last_sample && last_pix && last_acq) state <= SEARCH;
        end
        SEARCH: begin
          scan_bin <= scan_bin + 1'b1;
          if (last_bin) scan_pix <= scan_last ? '0 : scan_pix + 1'b1;
          if (scan_last) state <= UPDATE;
        end
        UPDATE: state <= ACC;
        default: state <= ACC;
      endcase
    end
  end

  // Histogram storage: count accepted words, wipe on reset or after publish.
  always_ff @(posedge clk) begin
    if (res || state == UPDATE) begin
      for (int p = 0; p < PIXEL_NUM; p++)
        for (int b = 0; b < NBINS; b++)
          hist[p][b] <= '0;
    end else if (accept) begin
      hist[pix][bin] <= bin_inc(hist[pix][bin]);
    end
  end

  // One argmax per pixel; only the pixel currently being walked is enabled.
  for (genvar p = 0; p < PIXEL_NUM; p++) begin : g_scan
    his_peak_scan #(
      .CNT_W (CNT_W),
      .IDX_W (BIN_BITS)
    ) u_scan (
      .clk   (clk),
      .res   (res),
      .en    ((state == SEARCH) && (scan_pix == PW'(p))),
      .start (scan_bin == '0),
      .val   (hist[p][scan_bin]),
      .idx   (scan_bin),
      .peak  (peak_bin[p])
    );
  end

  // Publish all pixels together as the lower edge of each peak bin.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int p = 0; p < PIXEL_NUM; p++) peakResult[p] <= '0;
    end else if (state == UPDATE) begin
      for (int p = 0; p < PIXEL_NUM; p++)
        peakResult[p] <= {peak_bin[p], {(DATA_W - BIN_BITS){1'b0}}};
    end
  end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Scoreboard bench for his_builder_fsm: stimulus pushes expected publishes
// (value and due edge) computed from a counting model; a monitor compares
// every cycle (publish, hold, reset) for two configurations.
module tb_his_builder_fsm;

  localparam int DW = 10, PN = 3, SPP = 2, BB = 4, NB = 16;
  localparam int ACQ_A = 2, CW_A = 8;
  localparam int ACQ_B = 8, CW_B = 2;
  localparam int LAT = PN * NB + 1;

  typedef logic [PN-1:0][DW-1:0] res_t;
  typedef struct packed {
    logic [31:0] due;
    res_t        v;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic mon_on = 1'b0;
  logic wr [2];
  logic [DW-1:0] din [2];
  logic [DW-1:0] pa [PN-1:0];
  logic [DW-1:0] pb [PN-1:0];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$];
  res_t hold [2];
  res_t act, want;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  his_builder_fsm #(.ACQ_NUM(ACQ_A), .CNT_W(CW_A)) u_dut_a (
    .clk(clk), .res(res), .wrEn(wr[0]), .data(din[0]), .peakResult(pa));
  his_builder_fsm #(.ACQ_NUM(ACQ_B), .CNT_W(CW_B)) u_dut_b (
    .clk(clk), .res(res), .wrEn(wr[1]), .data(din[1]), .peakResult(pb));

  function automatic res_t get(input int d);
    res_t r;
    for (int p = 0; p < PN; p++) r[p] = (d == 1) ? pb[p] : pa[p];
    return r;
  endfunction

  // Reference: count words per pixel/bin, apply counter width, strict argmax.
  function automatic res_t model(input int w[$], input int cw);
    int cnt [PN][NB];
    res_t r;
    for (int p = 0; p < PN; p++)
      for (int b = 0; b < NB; b++) cnt[p][b] = 0;
    for (int k = 0; k < w.size(); k++)
      cnt[(k / SPP) % PN][w[k] >> (DW - BB)]++;
    for (int p = 0; p < PN; p++) begin
      int best, bv;
      best = 0; bv = -1;
      for (int b = 0; b < NB; b++) begin
        int c;
`ifdef HIS_BIN_SAT_EN
        c = (cnt[p][b] > (1 << cw) - 1) ? (1 << cw) - 1 : cnt[p][b];
`else
        c = cnt[p][b] % (1 << cw);
`endif
        if (c > bv) begin bv = c; best = b; end
      end
      r[p] = DW'(best << (DW - BB));
    end
    return r;
  endfunction

  task automatic check(input int d, input string nm, input res_t a, input res_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, a, e);
    end
  endtask

  // Monitor: due publishes, reset-to-zero, otherwise value must hold.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        act = get(d);
        if (res) begin
          if (d == 0) q0.delete(); else q1.delete();
          hold[d] = '0;
          check(d, "reset", act, '0);
        end else if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin
          want = q0.pop_front().v; hold[d] = want;
          check(d, "publish", act, want);
        end else if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin
          want = q1.pop_front().v; hold[d] = want;
          check(d, "publish", act, want);
        end else begin
          if (d == 0 && q0.size() > 0 && q0[0].due < cyc) begin
            void'(q0.pop_front()); checks++; failures++;
            $display("FAIL overdue dut0 cyc=%0d got=missed want=publish", cyc);
          end
          if (d == 1 && q1.size() > 0 && q1[0].due < cyc) begin
            void'(q1.pop_front()); checks++; failures++;
            $display("FAIL overdue dut1 cyc=%0d got=missed want=publish", cyc);
          end
          check(d, "hold", act, hold[d]);
        end
      end
    end
  end

  // Drive one run, queue its expectation, then 49 cycles of junk writes.
  // abort_at >= 0 pulses reset that many junk cycles into the scan.
  task automatic run(input int d, input int w[$], input int gap_pct, input int abort_at);
    int last;
    exp_t e;
    for (int k = 0; k < w.size(); k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk); wr[d] = 1'b0; din[d] = DW'($urandom);
      end
      @(negedge clk); wr[d] = 1'b1; din[d] = DW'(w[k]); last = cyc + 1;
    end
    e.due = 32'(last + LAT);
    e.v   = model(w, (d == 1) ? CW_B : CW_A);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk); wr[d] = 1'($urandom_range(1)); din[d] = DW'($urandom);
      if (i == abort_at) begin
        res = 1'b1;
        @(negedge clk); res = 1'b0; wr[d] = 1'b0;
        return;
      end
    end
  endtask

  function automatic void rand_words(output int w[$], input int n);
    w = {};
    for (int k = 0; k < n; k++) w.push_back(int'($urandom_range(1023)));
  endfunction

  // Pixel-0 words come from p0 in order; other pixels random.
  function automatic void pix0_words(output int w[$], input int p0[$], input int n);
    int j;
    j = 0; w = {};
    for (int k = 0; k < n; k++)
      if ((k / SPP) % PN == 0) begin w.push_back(p0[j]); j++; end
      else w.push_back(int'($urandom_range(1023)));
  endfunction

  initial begin
    int w[$], p0[$];
    int na, nbw, t;
    na  = PN * SPP * ACQ_A;
    nbw = PN * SPP * ACQ_B;
    wr[0] = 1'b0; wr[1] = 1'b0; din[0] = '0; din[1] = '0;
    hold[0] = '0; hold[1] = '0;

    // Reset for two edges while writing.
    @(negedge clk); mon_on = 1'b1; res = 1'b1; wr[0] = 1'b1; din[0] = 10'd1000;
    @(negedge clk);
    @(negedge clk); res = 1'b0; wr[0] = 1'b0;

    w = '{108, 511, 1022, 1022, 200, 90, 300, 500, 50, 1000, 48, 90};
    run(0, w, 0, -1);
    run(0, w, 30, -1);
    w = {}; for (int k = 0; k < na; k++) w.push_back(0);
    run(0, w, 10, -1);
    p0 = '{64, 128, 64, 128};
    pix0_words(w, p0, na);
    run(0, w, 0, -1);
    for (int r = 0; r < 4; r++) begin rand_words(w, na); run(0, w, 20, -1); end
    rand_words(w, na); run(0, w, 0, 20);
    rand_words(w, na); run(0, w, 15, -1);
    @(negedge clk); wr[0] = 1'b0;

    // Narrow counters: 16 words land in pixel 0.
    p0 = {};
    for (int k = 0; k < 16; k++)
      p0.push_back(k < 4 ? 192 + int'($urandom_range(63)) : 320 + int'($urandom_range(63)));
    pix0_words(w, p0, nbw); run(1, w, 0, -1);
    p0 = {};
    for (int k = 0; k < 16; k++)
      p0.push_back(k < 2 ? 192 : (k < 4 ? 64 + int'($urandom_range(63)) : 320));
    pix0_words(w, p0, nbw); run(1, w, 10, -1);
    for (int r = 0; r < 2; r++) begin rand_words(w, nbw); run(1, w, 10, -1); end
    @(negedge clk); wr[1] = 1'b0;

    t = 0;
    while ((q0.size() > 0 || q1.size() > 0) && t < 500) begin @(negedge clk); t++; end
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d want=0", q0.size() + q1.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
